accumulator_stage: RTL and testbench
====================================

# accumulator_stage

Sequential accumulator that consumes the sum and carry of the team's 4-bit ripple adder datapath and holds a running total across operations. Operands arrive one at a time over a valid/ready handshake. A three-state FSM adds each operand to the held total, optionally chaining the previous carry, and registers the result with a one-cycle result strobe. The block sits directly downstream of the adder and replaces the lab's combinational-only sum with a stateful total suitable for driving LEDs/HEX displays.

## Interface
- WIDTH, 4, operand/accumulator width in bits (adder chain length)
- COUNT_W, 8, width of the accepted-operation counter
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- data_in  in  WIDTH  operand
- in_valid  in  1  operand present
- in_ready  out  1  block can accept an operand this cycle
- mode  in  1  0 = accumulate (acc + data_in + cin), 1 = load (acc <= data_in)
- chain  in  1  1 = cin is the registered cout from the previous op; 0 = cin is 0
- acc  out  WIDTH  held total
- cout  out  1  carry out of the most recent accumulate
- sticky_ovf  out  1  set on overflow, cleared only by reset or a load
- op_count  out  COUNT_W  number of accepted operations, wraps modulo 2^COUNT_W
- out_valid  out  1  one-cycle strobe: acc/cout updated

## Operation
- Reset values: acc=0, cout=0, sticky_ovf=0, op_count=0, out_valid=0, in_ready=1, state=IDLE.
- FSM states:
  - IDLE: in_ready=1. On in_valid=1, capture data_in, mode and chain; go to EXEC.
  - EXEC: in_ready=0. Compute and register the result, then go to RESULT.
  - RESULT: in_ready=0, out_valid=1. Go to IDLE unconditionally.
- Accumulate (mode=0):
  - sum = acc + operand + cin, with the ripple carry computed bit-serially over WIDTH full-adder cells.
  - acc <= sum[WIDTH-1:0], cout <= carry out of the MSB.
  - sticky_ovf |= overflow flag (see Configuration).
- Load (mode=1): acc <= operand, cout <= 0, sticky_ovf <= 0; chain is ignored.
- Carry chaining: with chain=1, cin is the registered cout from the previous op. With chain=0, cin=0. After reset or a load, cout is 0, so chaining behaves as cin=0.
- op_count increments by 1 in EXEC for every accepted op, either mode. It wraps from 2^COUNT_W-1 to 0 with no flag.
- in_valid asserted outside IDLE is ignored. data_in is not sampled, nothing is queued, and the upstream must hold the operand until it sees in_ready=1.
- Arithmetic wraps modulo 2^WIDTH. No saturation.

## Timing
- Handshake: a transfer occurs on the rising edge where in_valid=1 and in_ready=1.
- Transfer at edge N:
  - state=EXEC during cycle N..N+1.
  - acc, cout, sticky_ovf and op_count are updated at edge N+1.
  - out_valid=1 during cycle N+1..N+2.
  - in_ready=1 again after edge N+2.
- Throughput: one operation per 3 cycles. Latency from acceptance to out_valid: 1 cycle.
- in_ready is a registered function of state only. There is no combinational path from in_valid to in_ready.
- Reset asserted mid-operation (EXEC or RESULT) immediately forces reset values. The in-flight op is discarded and not counted. The first edge after reset release may accept.
- Back-to-back: if in_valid is held high continuously, a new op is accepted on every third edge.

## Configuration
- ACC_SIGNED_OVF_EN defined: the overflow flag is two's-complement signed overflow. It is set when the operand MSB and the pre-add acc MSB are equal and the result MSB differs from them. cout is still reported but does not affect sticky_ovf.
- ACC_SIGNED_OVF_EN undefined: the overflow flag is the unsigned carry out, so sticky_ovf |= cout of each accumulate.

## Test plan
- Reset, then load 4'h3, then accumulate 4'h4 with chain=0 -> acc=4'h7, cout=0, sticky_ovf=0, op_count=2, out_valid high exactly one cycle per op.
- Load 4'hF, then accumulate 4'h1 with chain=0 -> acc=4'h0, cout=1. sticky_ovf=1 when unsigned (macro off). sticky_ovf=0 when ACC_SIGNED_OVF_EN is defined (-1+1).
- Same sequence, then accumulate 4'h0 with chain=1 -> acc=4'h1, cout=0 (the carry was consumed). sticky_ovf remains set until the next load.
- With ACC_SIGNED_OVF_EN: load 4'h7, accumulate 4'h1 -> acc=4'h8, cout=0, sticky_ovf=1.
- Hold in_valid=1 for 9 cycles with operand 4'h1, mode=0 -> exactly 3 ops accepted, in_ready pattern 1,0,0 repeating, final acc=4'h3.
- Assert reset during EXEC of an accumulate -> all outputs return to reset values asynchronously, op_count=0, and no out_valid pulse is seen.

Source files
------------

// File: rtl/accumulator_stage.sv
// Handshaked 3-state accumulator: a ripple adder adds each operand to a held total.
// Optional macro ACC_SIGNED_OVF_EN switches sticky_ovf from unsigned carry to signed overflow.
module accumulator_stage #(
  parameter int WIDTH   = 4,
  parameter int COUNT_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               mode,
  input  logic               chain,
  output logic [WIDTH-1:0]   acc,
  output logic               cout,
  output logic               sticky_ovf,
  output logic [COUNT_W-1:0] op_count,
  output logic               out_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   operand_reg, operand_next;
  logic               mode_reg, mode_next;
  logic               chain_reg, chain_next;
  logic [WIDTH-1:0]   acc_reg, acc_next;
  logic               cout_reg, cout_next;
  logic               sticky_reg, sticky_next;
  logic [COUNT_W-1:0] count_reg, count_next;
  logic               out_valid_reg, out_valid_next;
  logic               in_ready_reg, in_ready_next;

  // Ripple-carry chain; carry-in is the previous carry only when chaining.
  logic [WIDTH:0]     carry;
  logic [WIDTH-1:0]   sum_bits;
  logic               ovf_flag;

  assign carry[0] = chain_reg & cout_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign sum_bits[gi]  = acc_reg[gi] ^ operand_reg[gi] ^ carry[gi];
      assign carry[gi+1]   = (acc_reg[gi] & operand_reg[gi]) |
                             (carry[gi] & (acc_reg[gi] ^ operand_reg[gi]));
    end
  endgenerate

`ifdef ACC_SIGNED_OVF_EN
  assign ovf_flag = (acc_reg[WIDTH-1] == operand_reg[WIDTH-1]) &&
                    (sum_bits[WIDTH-1] != acc_reg[WIDTH-1]);
`else
  assign ovf_flag = carry[WIDTH];
`endif

  always_comb begin
    state_next     = state_reg;
    operand_next   = operand_reg;
    mode_next      = mode_reg;
    chain_next     = chain_reg;
    acc_next       = acc_reg;
    cout_next      = cout_reg;
    sticky_next    = sticky_reg;
    count_next     = count_reg;
    out_valid_next = 1'b0;
    in_ready_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          operand_next = data_in;
          mode_next    = mode;
          chain_next   = chain;
          state_next   = EXEC;
        end
      end
      EXEC: begin
        if (mode_reg) begin
          acc_next    = operand_reg;
          cout_next   = 1'b0;
          sticky_next = 1'b0;
        end else begin
          acc_next    = sum_bits;
          cout_next   = carry[WIDTH];
          sticky_next = sticky_reg | ovf_flag;
        end
        count_next = count_reg + COUNT_W'(1);
        state_next = RESULT;
      end
      RESULT: state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Handshake flags are registered copies of the upcoming state.
    in_ready_next  = (state_next == IDLE);
    out_valid_next = (state_next == RESULT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      operand_reg   <= '0;
      mode_reg      <= 1'b0;
      chain_reg     <= 1'b0;
      acc_reg       <= '0;
      cout_reg      <= 1'b0;
      sticky_reg    <= 1'b0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      state_reg     <= state_next;
      operand_reg   <= operand_next;
      mode_reg      <= mode_next;
      chain_reg     <= chain_next;
      acc_reg       <= acc_next;
      cout_reg      <= cout_next;
      sticky_reg    <= sticky_next;
      count_reg     <= count_next;
      out_valid_reg <= out_valid_next;
      in_ready_reg  <= in_ready_next;
    end
  end

  assign in_ready   = in_ready_reg;
  assign out_valid  = out_valid_reg;
  assign acc        = acc_reg;
  assign cout       = cout_reg;
  assign sticky_ovf = sticky_reg;
  assign op_count   = count_reg;

endmodule

// File: tb/tb_accumulator_stage.sv
// Self-checking bench for accumulator_stage: directed cases, back-to-back, async reset, random ops.
module tb_accumulator_stage;
  localparam int WIDTH   = 4;
  localparam int COUNT_W = 8;
  localparam int MOD     = 1 << WIDTH;
  localparam int CMOD    = 1 << COUNT_W;

  logic               clock;
  logic               reset;
  logic [WIDTH-1:0]   data_in;
  logic               in_valid;
  logic               in_ready;
  logic               mode;
  logic               chain;
  logic [WIDTH-1:0]   acc;
  logic               cout;
  logic               sticky_ovf;
  logic [COUNT_W-1:0] op_count;
  logic               out_valid;

  int checks = 0;
  int errors = 0;

  // Reference state, updated arithmetically per accepted operation
  int m_acc, m_cout, m_st, m_cnt;

  accumulator_stage #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .chain(chain), .acc(acc), .cout(cout),
    .sticky_ovf(sticky_ovf), .op_count(op_count), .out_valid(out_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0; m_cout = 0; m_st = 0; m_cnt = 0;
  endtask

  task automatic model_step(input int op, input int md, input int ch);
    int cin, s, sa, so, ss, ovf;
    if (md != 0) begin
      m_acc = op; m_cout = 0; m_st = 0;
    end else begin
      cin = (ch != 0) ? m_cout : 0;
      s   = m_acc + op + cin;
      sa  = (m_acc >= MOD/2) ? m_acc - MOD : m_acc;
      so  = (op >= MOD/2) ? op - MOD : op;
      ss  = sa + so + cin;
      m_acc  = s % MOD;
      m_cout = s / MOD;
`ifdef ACC_SIGNED_OVF_EN
      ovf = (ss > MOD/2 - 1 || ss < -(MOD/2)) ? 1 : 0;
`else
      ovf = m_cout;
`endif
      if (ovf != 0) m_st = 1;
    end
    m_cnt = (m_cnt + 1) % CMOD;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_acc"}, 32'(acc), 32'(m_acc));
    chk({tag, "_cout"}, 32'(cout), 32'(m_cout));
    chk({tag, "_sticky"}, 32'(sticky_ovf), 32'(m_st));
    chk({tag, "_count"}, 32'(op_count), 32'(m_cnt));
  endtask

  // Called at a negedge; returns at the negedge after the result strobe ends.
  task automatic do_op(input string tag, input int op, input int md, input int ch);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_ready_wait"}, 32'(in_ready), 32'd1);
    data_in  = WIDTH'(op);
    mode     = md[0];
    chain    = ch[0];
    in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    model_step(op, md, ch);
    chk({tag, "_exec_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_exec_ov"}, 32'(out_valid), 32'd0);
    @(negedge clock);
    chk({tag, "_res_ov"}, 32'(out_valid), 32'd1);
    check_state(tag);
    @(negedge clock);
    chk({tag, "_post_ov"}, 32'(out_valid), 32'd0);
    chk({tag, "_post_ready"}, 32'(in_ready), 32'd1);
    $display("op %s data=%0h mode=%0d chain=%0d -> acc=%0h cout=%0d sticky=%0d count=%0d",
             tag, op, md, ch, acc, cout, sticky_ovf, op_count);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; data_in = '0; mode = 1'b0; chain = 1'b0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    check_state("rst");
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_ov", 32'(out_valid), 32'd0);
    reset = 1'b0;

    // Load 3 then add 4
    do_op("tp1_load", 3, 1, 0);
    do_op("tp1_add", 4, 0, 0);
    chk("tp1_acc7", 32'(acc), 32'h7);
    chk("tp1_cnt2", 32'(op_count), 32'd2);

    // Carry out of F+1, then consume it with chain
    do_op("tp2_load", 15, 1, 0);
    do_op("tp2_add", 1, 0, 0);
    chk("tp2_acc0", 32'(acc), 32'h0);
    chk("tp2_cout1", 32'(cout), 32'd1);
`ifdef ACC_SIGNED_OVF_EN
    chk("tp2_sticky", 32'(sticky_ovf), 32'd0);
`else
    chk("tp2_sticky", 32'(sticky_ovf), 32'd1);
`endif
    do_op("tp3_chain", 0, 0, 1);
    chk("tp3_acc1", 32'(acc), 32'h1);
    chk("tp3_cout0", 32'(cout), 32'd0);

    // Signed boundary 7+1; load clears sticky first
    do_op("tp4_load", 7, 1, 0);
    chk("tp4_sticky_clr", 32'(sticky_ovf), 32'd0);
    do_op("tp4_add", 1, 0, 0);
    chk("tp4_acc8", 32'(acc), 32'h8);
`ifdef ACC_SIGNED_OVF_EN
    chk("tp4_sticky", 32'(sticky_ovf), 32'd1);
`else
    chk("tp4_sticky", 32'(sticky_ovf), 32'd0);
`endif

    // Back-to-back: in_valid held for 9 edges
    do_op("b2b_load", 0, 1, 0);
    data_in = WIDTH'(1); mode = 1'b0; chain = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("b2b_ready", 32'(in_ready), (i % 3 == 0) ? 32'd1 : 32'd0);
      chk("b2b_ov", 32'(out_valid), (i % 3 == 2) ? 32'd1 : 32'd0);
      if (in_ready === 1'b1) model_step(1, 0, 0);
      @(negedge clock);
    end
    in_valid = 1'b0;
    chk("b2b_acc3", 32'(acc), 32'h3);
    check_state("b2b");
    $display("b2b final acc=%0h count=%0d", acc, op_count);

    // Async reset during EXEC
    do_op("ar_load", 5, 1, 0);
    data_in = WIDTH'(2); mode = 1'b0; chain = 1'b0; in_valid = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_state("ar_async");
    chk("ar_async_ready", 32'(in_ready), 32'd1);
    chk("ar_async_ov", 32'(out_valid), 32'd0);
    @(negedge clock);
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("ar_hold_ov", 32'(out_valid), 32'd0);
    end
    reset = 1'b0;
    @(negedge clock);
    chk("ar_rel_ov", 32'(out_valid), 32'd0);
    check_state("ar_rel");
    $display("async reset -> acc=%0h count=%0d ready=%0d", acc, op_count, in_ready);

    // Random ops, enough to wrap op_count
    for (int i = 0; i < 270; i++) begin
      int op, md, ch;
      op = int'($urandom_range(MOD - 1, 0));
      md = ($urandom_range(7, 0) == 0) ? 1 : 0;
      ch = int'($urandom_range(1, 0));
      do_op("rnd", op, md, ch);
    end
    chk("rnd_wrap_count", 32'(op_count), 32'(270 % CMOD));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
